// File: rtl/axi_ram_slave.sv
// AXI3-style single-port RAM slave: one transaction at a time, 32-bit beats,
// FIXED/INCR bursts, SLVERR for addresses beyond the implemented depth.
module axi_ram_slave #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic        aclk,
  input  logic        aresetn,
  // read address channel
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  // read data channel
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  // write address channel
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  // write data channel
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  // write response channel
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned Depth      = 1 << ADDR_W;
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlverr = 2'b10;

  typedef enum logic [1:0] {StIdle, StRd, StWrData, StWrResp} state_e;

  state_e            state_q, state_d;
  logic              rr_q, rr_d;        // 1: write wins the next AR/AW collision
  logic [3:0]        id_q, id_d;
  logic [3:0]        len_q, len_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              oor_q, oor_d;      // current beat lies outside the RAM
  logic              fixed_q, fixed_d;
  logic              err_q, err_d;      // sticky: some write beat was dropped
  logic [ADDR_W:0]   idx_inc;
  logic              beat_adv;
  logic              mem_we;
  logic [31:0]       mem_q [Depth];

  // Sizes, W id and wlast carry no information for this slave.
  logic unused_inputs;
  assign unused_inputs = ^{arsize, awsize, wid, wlast, araddr[1:0], awaddr[1:0]};

  // Next-state, channel outputs and burst address advance.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    id_d     = id_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    oor_d    = oor_q;
    fixed_d  = fixed_q;
    err_d    = err_q;
    arready  = 1'b0;
    awready  = 1'b0;
    rid      = '0;
    rdata    = '0;
    rresp    = RespOkay;
    rlast    = 1'b0;
    rvalid   = 1'b0;
    wready   = 1'b0;
    bid      = '0;
    bresp    = RespOkay;
    bvalid   = 1'b0;
    beat_adv = 1'b0;
    mem_we   = 1'b0;
    idx_inc  = {1'b0, idx_q} + {{ADDR_W{1'b0}}, 1'b1};

    unique case (state_q)
      StIdle: begin
        // Readies are gated by reset so they read 0 while aresetn is low.
        if (aresetn) begin
          if (arvalid && awvalid) begin
            arready = ~rr_q;
            awready = rr_q;
          end else begin
            arready = 1'b1;
            awready = 1'b1;
          end
        end
        if (arvalid && arready) begin
          id_d    = arid;
          idx_d   = araddr[ADDR_W+1:2];
          oor_d   = |araddr[31:ADDR_W+2];
          len_d   = arlen;
          fixed_d = (arburst == 2'b00);
          cnt_d   = '0;
          rr_d    = ~rr_q;
          state_d = StRd;
        end else if (awvalid && awready) begin
          id_d    = awid;
          idx_d   = awaddr[ADDR_W+1:2];
          oor_d   = |awaddr[31:ADDR_W+2];
          len_d   = awlen;
          fixed_d = (awburst == 2'b00);
          cnt_d   = '0;
          err_d   = 1'b0;
          rr_d    = ~rr_q;
          state_d = StWrData;
        end
      end
      StRd: begin
        rvalid = 1'b1;
        rid    = id_q;
        rdata  = oor_q ? '0 : mem_q[idx_q];
        rresp  = oor_q ? RespSlverr : RespOkay;
        rlast  = (cnt_q == len_q);
        if (rready) begin
          beat_adv = 1'b1;
          if (cnt_q == len_q) state_d = StIdle;
        end
      end
      StWrData: begin
        wready = 1'b1;
        if (wvalid) begin
          beat_adv = 1'b1;
          if (oor_q) err_d  = 1'b1;
          else       mem_we = 1'b1;
          if (cnt_q == len_q) state_d = StWrResp;
        end
      end
      StWrResp: begin
        bvalid = 1'b1;
        bid    = id_q;
        bresp  = err_q ? RespSlverr : RespOkay;
        if (bready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A carry out of the word index means later beats run off the RAM.
    if (beat_adv) begin
      cnt_d = cnt_q + 4'd1;
      if (!fixed_q) begin
        idx_d = idx_inc[ADDR_W-1:0];
        if (idx_inc[ADDR_W]) oor_d = 1'b1;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= StIdle;
      rr_q    <= 1'b0;
      id_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      oor_q   <= 1'b0;
      fixed_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      oor_q   <= oor_d;
      fixed_q <= fixed_d;
      err_q   <= err_d;
    end
  end

  // Byte-lane RAM write; contents deliberately survive reset.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      if (wstrb[0]) mem_q[idx_q][7:0]   <= wdata[7:0];
      if (wstrb[1]) mem_q[idx_q][15:8]  <= wdata[15:8];
      if (wstrb[2]) mem_q[idx_q][23:16] <= wdata[23:16];
      if (wstrb[3]) mem_q[idx_q][31:24] <= wdata[31:24];
    end
  end

endmodule

// File: doc/axi_ram_slave.md
AXI_RAM_SLAVE -- requirements
Module: axi_ram_slave

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 12, giving the word-address width; memory depth is 2**ADDR_W 32-bit words.
REQ-002 The module SHALL have port aclk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-003 The module SHALL have port aresetn, input, 1 bit, asynchronous active-low reset.
REQ-004 The module SHALL have port arid, input, 4 bits, read ID.
REQ-005 The module SHALL have port araddr, input, 32 bits, read start byte address.
REQ-006 The module SHALL have port arlen, input, 4 bits, read beats minus 1.
REQ-007 The module SHALL have port arsize, input, 3 bits, accepted and ignored (4-byte beats).
REQ-008 The module SHALL have port arburst, input, 2 bits, 0=FIXED, any other value is treated as INCR.
REQ-009 The module SHALL have ports arvalid, input, 1 bit, and arready, output, 1 bit, forming the AR handshake.
REQ-010 The module SHALL have port rid, output, 4 bits, echo of the latched arid.
REQ-011 The module SHALL have port rdata, output, 32 bits, read beat data.
REQ-012 The module SHALL have port rresp, output, 2 bits, 0=OKAY, 2=SLVERR.
REQ-013 The module SHALL have port rlast, output, 1 bit, final read beat.
REQ-014 The module SHALL have ports rvalid, output, 1 bit, and rready, input, 1 bit, forming the R handshake.
REQ-015 The module SHALL have ports awid, input, 4 bits; awaddr, input, 32 bits; awlen, input, 4 bits; awsize, input, 3 bits; and awburst, input, 2 bits, with the same meanings as their AR counterparts.
REQ-016 The module SHALL have ports awvalid, input, 1 bit, and awready, output, 1 bit, forming the AW handshake.
REQ-017 The module SHALL have port wid, input, 4 bits, accepted and ignored.
REQ-018 The module SHALL have port wdata, input, 32 bits, write data.
REQ-019 The module SHALL have port wstrb, input, 4 bits, byte-lane enables.
REQ-020 The module SHALL have port wlast, input, 1 bit, accepted and ignored; burst length is taken from awlen only.
REQ-021 The module SHALL have ports wvalid, input, 1 bit, and wready, output, 1 bit, forming the W handshake.
REQ-022 The module SHALL have ports bid, output, 4 bits; bresp, output, 2 bits; bvalid, output, 1 bit; and bready, input, 1 bit, forming the B channel.

Function
REQ-023 The module SHALL implement an FSM with states IDLE, RD, WR_DATA and WR_RESP, and SHALL service one transaction at a time.
REQ-024 In IDLE, the module SHALL drive arready=1 and awready=1 combinationally, except that when arvalid and awvalid are both high, only the side granted by a 1-bit round-robin flag is readied; the flag flips after each granted transaction and favours read after reset.
REQ-025 On an AR handshake, the module SHALL latch id, address word index (addr[ADDR_W+1:2]), out-of-range flag (addr[31:ADDR_W+2]!=0), len and burst type, clear the beat counter and enter RD.
REQ-026 In RD, the module SHALL assert rvalid from the cycle after the AR handshake, with rdata = mem[index] (0 if out of range), rresp = SLVERR if out of range else OKAY, and rlast = (count==len); all R outputs SHALL hold stable while rvalid=1 and rready=0.
REQ-027 On each R handshake, the module SHALL increment the count and, for INCR, increment the index, with an index carry out of ADDR_W bits setting the out-of-range flag for later beats; FIXED SHALL keep the index; the handshake on the last beat SHALL return the FSM to IDLE with rvalid=0 the next cycle.
REQ-028 On an AW handshake, the module SHALL latch the same fields, clear the sticky error and enter WR_DATA, where wready=1.
REQ-029 On each W handshake, the module SHALL write each byte lane with wstrb=1 into mem[index] when in range, drop the write and set the sticky error when out of range, and advance as in REQ-027; the beat where count==len SHALL move the FSM to WR_RESP.
REQ-030 In WR_RESP, the module SHALL drive bvalid=1, bid = latched id and bresp = SLVERR if the sticky error is set else OKAY; the B handshake SHALL return the FSM to IDLE.
REQ-031 Write-then-read latency: a read issued after bvalid SHALL observe the written data.

Reset
REQ-032 While aresetn=0, the module SHALL force state=IDLE and arready, awready, rvalid, wready, bvalid, rlast = 0, and rid, bid, rdata, rresp, bresp = 0; memory contents SHALL NOT be reset.
REQ-033 Reset asserted mid-burst SHALL abandon the transaction with no response issued; beats already written SHALL remain in memory.

Verification
REQ-034 AW 0x100, len=3, INCR, data 0x11..0x44, wstrb=F -> bvalid with bresp=0, bid echoed; then AR 0x100, len=3 -> rdata 0x11,0x22,0x33,0x44, rlast on the 4th beat only.
REQ-035 Write 0xAABBCCDD with wstrb=4'b0101 over 0x00000000 -> readback 0x00BB00DD.
REQ-036 rready held low 5 cycles mid-burst -> rdata, rlast, rid unchanged; no beat lost.
REQ-037 arvalid and awvalid raised in the same cycle twice in succession -> read granted first, then write.
REQ-038 AR at 0x00004000 with ADDR_W=12 -> rresp=2, rdata=0; write to the same address -> bresp=2 and memory unchanged.
REQ-039 Reset asserted during the 2nd W beat -> all valids and readies 0; the next transaction completes normally.
